// File: rtl/mac_reg_pkg.sv
// rtl/mac_reg_pkg.sv - shared types and register map for the MAC/PCS init sequencer
package mac_reg_pkg;

  typedef enum logic [1:0] {
    OP_WRITE = 2'd0,
    OP_WRVER = 2'd1,
    OP_POLL  = 2'd2
  } op_e;

  localparam logic [7:0] CMD_CFG    = 8'h02;
  localparam logic [7:0] MAC0       = 8'h03;
  localparam logic [7:0] MAC1       = 8'h04;
  localparam logic [7:0] FRM_LEN    = 8'h05;
  localparam logic [7:0] PCS_CTRL   = 8'h80;
  localparam logic [7:0] PCS_IFMODE = 8'h94;

  localparam logic [31:0] TX_ENA    = 32'h0000_0001;
  localparam logic [31:0] RX_ENA    = 32'h0000_0002;
  localparam logic [31:0] PROMIS_EN = 32'h0000_0010;
  localparam logic [31:0] SW_RESET  = 32'h0000_2000;
  localparam logic [31:0] PCS_RESET = 32'h0000_8000;

  // AN enable, full duplex, 1000 Mb/s on top of the PCS reset bit
  localparam logic [31:0] PCS_CTRL_INIT = PCS_RESET | 32'h0000_1140;
  localparam logic [31:0] IFMODE_SGMII  = 32'h0000_0003;

  localparam int NUM_ENTRIES = 9;

  typedef struct packed {
    op_e         op;
    logic [7:0]  addr;
    logic [31:0] data;
    logic [31:0] mask;
  } entry_t;

  typedef enum logic [3:0] {
    S_IDLE, S_LOAD, S_WR, S_GAP, S_RD, S_CHK, S_NEXT, S_DONE, S_ERR
  } state_e;

endpackage

// File: rtl/mac_reg_rom.sv
// rtl/mac_reg_rom.sv - init table lookup with station address and frame length substituted
module mac_reg_rom
  import mac_reg_pkg::*;
#(
  parameter int MAX_FRM = 1518
) (
  input  logic [3:0]  index,
  input  logic [47:0] mac_addr,
  output logic [1:0]  op,
  output logic [7:0]  addr,
  output logic [31:0] data,
  output logic [31:0] mask
);

  entry_t ent;

  always_comb begin
    ent = '{op: OP_WRITE, addr: 8'h00, data: 32'h0, mask: 32'h0};
    unique case (index)
      4'd0: ent = '{op: OP_WRITE, addr: PCS_IFMODE, data: IFMODE_SGMII,  mask: 32'h0};
      4'd1: ent = '{op: OP_WRITE, addr: PCS_CTRL,   data: PCS_CTRL_INIT, mask: 32'h0};
      4'd2: ent = '{op: OP_POLL,  addr: PCS_CTRL,   data: 32'h0,         mask: PCS_RESET};
      4'd3: ent = '{op: OP_WRITE, addr: CMD_CFG,    data: SW_RESET,      mask: 32'h0};
      4'd4: ent = '{op: OP_POLL,  addr: CMD_CFG,    data: 32'h0,         mask: SW_RESET};
      // first octet on the wire lands in the low byte of MAC0
      4'd5: ent = '{op: OP_WRVER, addr: MAC0,
                    data: {mac_addr[23:16], mac_addr[31:24], mac_addr[39:32], mac_addr[47:40]},
                    mask: 32'hFFFF_FFFF};
      4'd6: ent = '{op: OP_WRVER, addr: MAC1,
                    data: {16'h0, mac_addr[7:0], mac_addr[15:8]}, mask: 32'h0000_FFFF};
      4'd7: ent = '{op: OP_WRVER, addr: FRM_LEN, data: 32'(MAX_FRM), mask: 32'h0000_FFFF};
      4'd8: ent = '{op: OP_WRVER, addr: CMD_CFG, data: TX_ENA | RX_ENA | PROMIS_EN,
                    mask: TX_ENA | RX_ENA | PROMIS_EN};
      default: ent = '{op: OP_WRITE, addr: 8'h00, data: 32'h0, mask: 32'h0};
    endcase
  end

  assign op   = ent.op;
  assign addr = ent.addr;
  assign data = ent.data;
  assign mask = ent.mask;

endmodule

// File: rtl/mac_reg_init.sv
// rtl/mac_reg_init.sv - Avalon-MM initiator that walks the MAC/PCS bring-up table
module mac_reg_init
  import mac_reg_pkg::*;
#(
  parameter int TIMEOUT  = 1024,
  parameter int POLL_MAX = 4096,
  parameter int MAX_FRM  = 1518
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [47:0] mac_addr,
  output logic [7:0]  address,
  output logic        write,
  output logic        read,
  output logic [31:0] writedata,
  input  logic [31:0] readdata,
  input  logic        waitrequest,
  output logic        busy,
  output logic        init_done,
  output logic        init_err,
  output logic [3:0]  err_index
);

  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int PW = (POLL_MAX > 1) ? $clog2(POLL_MAX) : 1;
  localparam logic [TW-1:0] WAIT_LAST = TW'(TIMEOUT - 1);
  localparam logic [PW-1:0] POLL_LAST = PW'(POLL_MAX - 1);
  localparam logic [3:0]    LAST_IDX  = 4'(NUM_ENTRIES - 1);

  state_e        state, state_nxt;
  logic [3:0]    index;
  logic [47:0]   mac_q;
  logic [31:0]   rd_q;
  logic [TW-1:0] wait_cnt;
  logic [PW-1:0] poll_cnt;
  logic [1:0]    ent_op;
  logic [7:0]    ent_addr;
  logic [31:0]   ent_data, ent_mask;
  op_e           cur_op;
  logic          idle_like, timeout_hit, poll_ok, ver_ok;

  mac_reg_rom #(.MAX_FRM(MAX_FRM)) u_rom (
    .index    (index),
    .mac_addr (mac_q),
    .op       (ent_op),
    .addr     (ent_addr),
    .data     (ent_data),
    .mask     (ent_mask)
  );

  assign cur_op      = op_e'(ent_op);
  assign idle_like   = (state == S_IDLE) || (state == S_DONE) || (state == S_ERR);
  // compare before increment so the counter never needs to hold TIMEOUT itself
  assign timeout_hit = waitrequest && (wait_cnt == WAIT_LAST);
  assign poll_ok     = (rd_q & ent_mask) == 32'h0;
  assign ver_ok      = (rd_q & ent_mask) == (ent_data & ent_mask);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE, S_DONE, S_ERR: if (start) state_nxt = S_LOAD;
      S_LOAD: state_nxt = (cur_op == OP_POLL) ? S_RD : S_WR;
      S_WR: begin
        if (timeout_hit)      state_nxt = S_ERR;
        else if (!waitrequest) state_nxt = (cur_op == OP_WRVER) ? S_GAP : S_NEXT;
      end
      S_GAP: state_nxt = S_RD;
      S_RD: begin
        if (timeout_hit)      state_nxt = S_ERR;
        else if (!waitrequest) state_nxt = S_CHK;
      end
      S_CHK: begin
        if (cur_op == OP_POLL) begin
          if (poll_ok)                    state_nxt = S_NEXT;
          else if (poll_cnt == POLL_LAST) state_nxt = S_ERR;
          else                            state_nxt = S_GAP;
        end else begin
          state_nxt = ver_ok ? S_NEXT : S_ERR;
        end
      end
      S_NEXT:  state_nxt = (index == LAST_IDX) ? S_DONE : S_LOAD;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    write     = (state == S_WR);
    read      = (state == S_RD);
    address   = (write || read) ? ent_addr : 8'h00;
    writedata = write ? ent_data : 32'h0;
    busy      = !idle_like;
    init_done = (state == S_DONE);
    init_err  = (state == S_ERR);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      index     <= '0;
      mac_q     <= '0;
      rd_q      <= '0;
      wait_cnt  <= '0;
      poll_cnt  <= '0;
      err_index <= '0;
    end else begin
      if (idle_like && start) begin
        index     <= '0;
        mac_q     <= mac_addr;
        err_index <= '0;
      end
      if (state == S_NEXT && index != LAST_IDX) index <= index + 4'd1;
      if (state == S_RD && !waitrequest) rd_q <= readdata;
      if (state == S_WR || state == S_RD) begin
        if (waitrequest) wait_cnt <= wait_cnt + TW'(1);
      end else begin
        wait_cnt <= '0;
      end
      if (state == S_LOAD)
        poll_cnt <= '0;
      else if (state == S_CHK && cur_op == OP_POLL && !poll_ok && poll_cnt != POLL_LAST)
        poll_cnt <= poll_cnt + PW'(1);
      if (state_nxt == S_ERR && state != S_ERR) err_index <= index;
    end
  end

endmodule

// File: tb/tb_mac_reg_init.sv
// tb/tb_mac_reg_init.sv - directed self-checking bench for mac_reg_init against a behavioural register slave
module tb_mac_reg_init;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [47:0] mac_addr = 48'h0;
  logic [7:0]  address;
  logic        write, read;
  logic [31:0] writedata;
  logic [31:0] readdata = 32'h0;
  logic        waitrequest = 1'b0;
  logic        busy, init_done, init_err;
  logic [3:0]  err_index;

  int n_chk = 0;
  int n_fail = 0;

  mac_reg_init #(.TIMEOUT(16), .POLL_MAX(12), .MAX_FRM(1518)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .mac_addr    (mac_addr),
    .address     (address),
    .write       (write),
    .read        (read),
    .writedata   (writedata),
    .readdata    (readdata),
    .waitrequest (waitrequest),
    .busy        (busy),
    .init_done   (init_done),
    .init_err    (init_err),
    .err_index   (err_index)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          wr;
    logic [7:0]  addr;
    logic [31:0] data;
  } acc_t;

  acc_t        log_q[$];
  logic [31:0] regs [256];
  int          stall_n = 0;
  int          stall_cnt = 0;
  int          pcs_busy_n = 0;
  int          pcs_pend = 0;
  bit          bad_frm = 0;
  bit          stuck_en = 0;
  logic [7:0]  stuck_addr = 8'h02;
  int          stuck_cycles = 0;
  int          viol = 0;
  int          unstable = 0;
  bit          in_acc = 0;
  bit          prev_done = 0;
  logic [7:0]  acc_addr;
  logic [31:0] acc_wd;
  logic [31:0] rdv;

  // slave decides waitrequest/readdata mid-cycle for the coming rising edge
  always @(negedge clk) begin
    if (!reset) begin
      waitrequest = 1'b0;
      in_acc = 0;
      prev_done = 0;
    end else if (write || read) begin
      if (write && read) viol++;
      if (!in_acc) begin
        if (prev_done) viol++;
        in_acc = 1;
        prev_done = 0;
        acc_addr = address;
        acc_wd = writedata;
        stall_cnt = 0;
      end else if (address !== acc_addr || writedata !== acc_wd) begin
        unstable++;
      end
      if (stuck_en && write && address == stuck_addr) begin
        waitrequest = 1'b1;
        stuck_cycles++;
      end else if (stall_cnt < stall_n) begin
        waitrequest = 1'b1;
        stall_cnt++;
      end else begin
        waitrequest = 1'b0;
        in_acc = 0;
        prev_done = 1;
        if (write) begin
          case (address)
            8'h80: begin
              regs[8'h80] = writedata & ~32'h8000;
              if (writedata[15]) pcs_pend = pcs_busy_n;
            end
            8'h02: regs[8'h02] = writedata & ~32'h2000;
            default: regs[address] = writedata;
          endcase
          log_q.push_back('{1'b1, address, writedata});
        end else begin
          rdv = regs[address];
          if (address == 8'h80 && pcs_pend != 0) begin
            rdv[15] = 1'b1;
            if (pcs_pend > 0) pcs_pend--;
          end
          if (address == 8'h05 && bad_frm) rdv = 32'h0000_05DC;
          readdata = rdv;
          log_q.push_back('{1'b0, address, rdv});
        end
      end
    end else begin
      waitrequest = 1'b0;
      in_acc = 0;
      prev_done = 0;
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic pulse_start(input logic [47:0] mac);
    mac_addr = mac;
    start = 1'b1;
    @(posedge clk);
    #2;
    start = 1'b0;
    mac_addr = 48'hDEAD_BEEF_CAFE;
  endtask

  task automatic wait_end(input string tag);
    int n = 0;
    while (!(init_done || init_err) && n < 2000) begin
      tick(1);
      n++;
    end
    chk({tag, "_finished"}, 64'(init_done | init_err), 64'd1);
  endtask

  task automatic clear_slave();
    log_q.delete();
    stall_n = 0;
    pcs_busy_n = 0;
    pcs_pend = 0;
    bad_frm = 0;
    stuck_en = 0;
    stuck_cycles = 0;
    viol = 0;
    unstable = 0;
  endtask

  function automatic int reads_of(input logic [7:0] a);
    int n = 0;
    foreach (log_q[i]) if (!log_q[i].wr && log_q[i].addr == a) n++;
    return n;
  endfunction

  task automatic check_seq(input string tag, input logic [31:0] m0, input logic [31:0] m1);
    logic [40:0] exp_q [13];
    exp_q[0]  = {1'b1, 8'h94, 32'h0000_0003};
    exp_q[1]  = {1'b1, 8'h80, 32'h0000_9140};
    exp_q[2]  = {1'b0, 8'h80, 32'h0000_1140};
    exp_q[3]  = {1'b1, 8'h02, 32'h0000_2000};
    exp_q[4]  = {1'b0, 8'h02, 32'h0000_0000};
    exp_q[5]  = {1'b1, 8'h03, m0};
    exp_q[6]  = {1'b0, 8'h03, m0};
    exp_q[7]  = {1'b1, 8'h04, m1};
    exp_q[8]  = {1'b0, 8'h04, m1};
    exp_q[9]  = {1'b1, 8'h05, 32'h0000_05EE};
    exp_q[10] = {1'b0, 8'h05, 32'h0000_05EE};
    exp_q[11] = {1'b1, 8'h02, 32'h0000_0013};
    exp_q[12] = {1'b0, 8'h02, 32'h0000_0013};
    chk({tag, "_len"}, 64'(log_q.size()), 64'd13);
    for (int i = 0; i < 13 && i < log_q.size(); i++)
      chk($sformatf("%s[%0d]", tag, i), {23'h0, log_q[i].wr, log_q[i].addr, log_q[i].data}, {23'h0, exp_q[i]});
  endtask

  initial begin
    tick(3);
    chk("rst_strobes", {write, read, busy, init_done, init_err}, 64'h0);
    chk("rst_address", address, 64'h0);
    chk("rst_wdata", writedata, 64'h0);
    chk("rst_err_index", err_index, 64'h0);
    reset = 1'b1;
    tick(2);

    // zero-wait bring-up, mac_addr changed after start must be ignored
    clear_slave();
    pulse_start(48'h0011_2233_4455);
    chk("t1_busy", {busy, init_done, init_err}, 64'b100);
    wait_end("t1");
    chk("t1_status", {busy, init_done, init_err}, 64'b010);
    check_seq("t1_seq", 32'h3322_1100, 32'h0000_5544);
    chk("t1_viol", viol, 64'd0);

    // three stall cycles on every access
    clear_slave();
    stall_n = 3;
    pulse_start(48'h0A0B_0C0D_0E0F);
    wait_end("t2");
    chk("t2_status", {busy, init_done, init_err}, 64'b010);
    check_seq("t2_seq", 32'h0D0C_0B0A, 32'h0000_0F0E);
    chk("t2_unstable", unstable, 64'd0);
    chk("t2_viol", viol, 64'd0);

    // PCS reset busy for 11 reads: 12th read (the last allowed) passes
    clear_slave();
    pcs_busy_n = 11;
    pulse_start(48'h0011_2233_4455);
    wait_end("t3");
    chk("t3_status", {init_done, init_err}, 64'b10);
    chk("t3_reads80", reads_of(8'h80), 64'd12);

    // PCS reset never clears
    clear_slave();
    pcs_busy_n = -1;
    pulse_start(48'h0011_2233_4455);
    wait_end("t4");
    chk("t4_status", {busy, init_done, init_err}, 64'b001);
    chk("t4_err_index", err_index, 64'd2);
    chk("t4_reads80", reads_of(8'h80), 64'd12);

    // frame length readback mismatch, restarted from ERR
    clear_slave();
    bad_frm = 1;
    pulse_start(48'h0011_2233_4455);
    chk("t5_cleared", {init_err, err_index}, 64'h0);
    wait_end("t5");
    tick(30);
    chk("t5_status", {init_done, init_err}, 64'b01);
    chk("t5_err_index", err_index, 64'd7);
    chk("t5_accesses", log_q.size(), 64'd11);

    // waitrequest stuck on the SW_RESET write
    clear_slave();
    stuck_en = 1;
    pulse_start(48'h0011_2233_4455);
    wait_end("t6");
    chk("t6_stall_cycles", stuck_cycles, 64'd16);
    chk("t6_status", {write, read, init_done, init_err}, 64'b0001);
    chk("t6_err_index", err_index, 64'd3);
    clear_slave();
    pulse_start(48'h0011_2233_4455);
    wait_end("t6b");
    chk("t6b_status", {init_done, init_err, err_index}, 64'b10_0000);

    // asynchronous reset during the MAC0 write
    clear_slave();
    stall_n = 2;
    pulse_start(48'h0011_2233_4455);
    begin
      int n = 0;
      while (!(write && address == 8'h03) && n < 500) begin
        tick(1);
        n++;
      end
      chk("t7_reached_mac0", {write, address}, {1'b1, 8'h03});
    end
    #1;
    reset = 1'b0;
    #1;
    chk("t7_outputs", {address, write, read, writedata, busy, init_done, init_err, err_index}, 64'h0);
    tick(2);
    reset = 1'b1;
    tick(3);
    chk("t7_idle", {write, read, busy, init_done, init_err}, 64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
